// File: rtl/envelope_follower.sv
// -----------------------------------------------------------------------------
// envelope_follower
//
// Peak-style envelope detector with a hysteresis note gate and a hold timer.
//
// Each qualified sample is rectified (|x| << 15). The envelope then moves toward
// that magnitude. It rises by at most `attack` and falls by at most `rel` per
// sample, and a zero rate snaps straight to the magnitude. A three-state gate
// (IDLE / ON / HOLD) turns the envelope into a note indication. The gate opens
// at threshold_on and starts closing below min(threshold_off, threshold_on). It
// closes only after hold_ms millisecond ticks spent in HOLD.
//
// Optional feature: define ENVELOPE_FOLLOWER_PEAK_EN to add peak_out. This
// output holds the largest envelope seen since the last note-on.
//
// Parameters
//   MS_CYCLES      clk cycles per millisecond tick (default 50000)
//
// Ports
//   clk            clock, rising edge
//   reset          asynchronous active-low reset
//   sample_in      signed 16-bit audio sample
//   sample_valid   qualifies sample_in, one sample per high cycle
//   attack         max rising step per sample (0 = instantaneous)
//   rel            max falling step per sample (0 = instantaneous)
//   threshold_on   envelope level that opens the gate
//   threshold_off  envelope level below which the gate starts closing
//   hold_ms        hold time in millisecond ticks
//   env_out        registered envelope
//   env_valid      one-cycle pulse, env_out updated on the same edge
//   note_out       gate, high in ON and HOLD
//   peak_out       (ENVELOPE_FOLLOWER_PEAK_EN only) peak envelope of last note
//   note_on_pulse  one-cycle pulse on note_out rise
//   note_off_pulse one-cycle pulse on note_out fall
// -----------------------------------------------------------------------------
module envelope_follower #(
  parameter int unsigned MS_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  input  logic        [30:0] attack,
  input  logic        [30:0] rel,
  input  logic        [30:0] threshold_on,
  input  logic        [30:0] threshold_off,
  input  logic        [9:0]  hold_ms,
  output logic        [30:0] env_out,
  output logic               env_valid,
  output logic               note_out,
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
  output logic        [30:0] peak_out,
`endif
  output logic               note_on_pulse,
  output logic               note_off_pulse
);

  localparam int unsigned     MS_W    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [30:0]      env_q, env_d;
  logic             env_valid_q, env_valid_d;
  logic [MS_W-1:0]  ms_q, ms_d;
  logic [9:0]       hold_q, hold_d;
  logic             on_p_q, on_p_d;
  logic             off_p_q, off_p_d;

  // ---------------------------------------------------------------------------
  // Rectifier: the unsigned negate maps -32768 to 0x8000, so mag reaches 2^30
  // without overflow.
  // ---------------------------------------------------------------------------
  logic [15:0] s_u;
  logic [15:0] abs_s;
  logic [30:0] mag;

  always_comb begin
    s_u   = sample_in;
    abs_s = s_u[15] ? (~s_u + 16'd1) : s_u;
    mag   = {abs_s, 15'd0};
  end

  // ---------------------------------------------------------------------------
  // Envelope step. The rising sum is formed one bit wider, so a huge attack
  // clamps to mag instead of wrapping. Falling clamps at 0 before the max with
  // mag.
  // ---------------------------------------------------------------------------
  logic [31:0] rise_sum;
  logic [30:0] rise_v;
  logic [30:0] fall_lim;
  logic [30:0] fall_v;
  logic [30:0] env_new;

  always_comb begin
    rise_sum = {1'b0, env_q} + {1'b0, attack};
    rise_v   = (attack == '0 || rise_sum > {1'b0, mag}) ? mag : rise_sum[30:0];
    fall_lim = (rel > env_q) ? '0 : (env_q - rel);
    fall_v   = (rel == '0 || fall_lim < mag) ? mag : fall_lim;
    env_new  = (mag > env_q) ? rise_v : fall_v;
    env_d       = sample_valid ? env_new : env_q;
    env_valid_d = sample_valid;
  end

  // ---------------------------------------------------------------------------
  // Gate FSM
  // ---------------------------------------------------------------------------
  logic [30:0] off_lvl;
  logic        ms_wrap;
  logic [9:0]  hold_inc;
  logic        open_hit;
  logic        close_hit;

  always_comb begin
    off_lvl   = (threshold_off < threshold_on) ? threshold_off : threshold_on;
    open_hit  = sample_valid && (env_new >= threshold_on);
    close_hit = sample_valid && (env_new < off_lvl);
    ms_wrap   = (ms_q == MS_LAST);
    // Hold expiry tests the count as it stands after this cycle's tick. The
    // note therefore drops on the edge that completes the hold_ms-th tick.
    hold_inc  = (ms_wrap && hold_q != '1) ? (hold_q + 10'd1) : hold_q;
  end

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    hold_d  = hold_q;
    on_p_d  = 1'b0;
    off_p_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (open_hit) begin
          state_d = ST_ON;
          on_p_d  = 1'b1;
        end
      end

      ST_ON: begin
        if (close_hit) begin
          state_d = ST_HOLD;
          ms_d    = '0;
          hold_d  = '0;
        end
      end

      ST_HOLD: begin
        ms_d   = ms_wrap ? '0 : (ms_q + MS_W'(1));
        hold_d = hold_inc;
        // A reopening sample takes priority over hold expiry on the same edge.
        if (open_hit) begin
          state_d = ST_ON;
        end else if (hold_inc >= hold_ms) begin
          state_d = ST_IDLE;
          off_p_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      env_q       <= '0;
      env_valid_q <= 1'b0;
      ms_q        <= '0;
      hold_q      <= '0;
      on_p_q      <= 1'b0;
      off_p_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      env_q       <= env_d;
      env_valid_q <= env_valid_d;
      ms_q        <= ms_d;
      hold_q      <= hold_d;
      on_p_q      <= on_p_d;
      off_p_q     <= off_p_d;
    end
  end

  assign env_out        = env_q;
  assign env_valid      = env_valid_q;
  assign note_out       = (state_q != ST_IDLE);
  assign note_on_pulse  = on_p_q;
  assign note_off_pulse = off_p_q;

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
  // ---------------------------------------------------------------------------
  // Peak tracker: loaded on note-on, then raised only while a note is
  // sounding. It keeps its value through IDLE until the next note-on.
  // ---------------------------------------------------------------------------
  logic [30:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (on_p_d) begin
      peak_d = env_new;
    end else if (state_q != ST_IDLE && sample_valid && env_new > peak_q) begin
      peak_d = env_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// -----------------------------------------------------------------------------
// tb_envelope_follower
//
// Bench for envelope_follower. A behavioural model tracks envelope and gate
// with plain integer arithmetic. Hold timing is derived from cycles elapsed
// since HOLD entry. Directed sequences pin the model with literal values, and
// a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_envelope_follower;

  localparam int MS = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic        [30:0] attack = '0;
  logic        [30:0] rel = '0;
  logic        [30:0] threshold_on = 31'h7FFFFFFF;
  logic        [30:0] threshold_off = 31'h7FFFFFFF;
  logic        [9:0]  hold_ms = '0;
  logic        [30:0] env_out;
  logic               env_valid;
  logic               note_out;
  logic               note_on_pulse;
  logic               note_off_pulse;
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
  logic        [30:0] peak_out;
`endif

  envelope_follower #(.MS_CYCLES(MS)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .attack         (attack),
    .rel            (rel),
    .threshold_on   (threshold_on),
    .threshold_off  (threshold_off),
    .hold_ms        (hold_ms),
    .env_out        (env_out),
    .env_valid      (env_valid),
    .note_out       (note_out),
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    .peak_out       (peak_out),
`endif
    .note_on_pulse  (note_on_pulse),
    .note_off_pulse (note_off_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  longint m_env = 0;
  longint m_peak = 0;
  bit     m_valid = 0;
  bit     m_note = 0;
  bit     m_hold = 0;
  bit     m_on_p = 0;
  bit     m_off_p = 0;
  int     m_hold_k = 0;

  task automatic model_clear();
    m_env = 0; m_peak = 0; m_valid = 0; m_note = 0;
    m_hold = 0; m_on_p = 0; m_off_p = 0; m_hold_k = 0;
  endtask

  task automatic model_step();
    longint mag, a, r, ton, toff, off;
    int     s, ticks;
    bit     expire, was_note;
    a = attack; r = rel; ton = threshold_on; toff = threshold_off;
    m_on_p = 0; m_off_p = 0; m_valid = sample_valid;
    expire = 0; was_note = m_note;
    if (m_hold) begin
      m_hold_k++;
      ticks = m_hold_k / MS;
      if (ticks > 1023) ticks = 1023;
      expire = (ticks >= int'(hold_ms));
    end
    if (sample_valid) begin
      s = int'(sample_in);
      mag = longint'(s < 0 ? -s : s) * 32768;
      if (mag > m_env) m_env = (a == 0 || m_env + a > mag) ? mag : m_env + a;
      else             m_env = (r == 0 || m_env - r < mag) ? mag : m_env - r;
      off = (toff < ton) ? toff : ton;
      if (!m_note) begin
        if (m_env >= ton) begin m_note = 1; m_on_p = 1; m_peak = m_env; end
      end else if (!m_hold) begin
        if (m_env < off) begin m_hold = 1; m_hold_k = 0; end
      end else if (m_env >= ton) begin
        m_hold = 0; expire = 0;
      end
      if (was_note && m_env > m_peak) m_peak = m_env;
    end
    if (expire && m_hold) begin
      m_hold = 0; m_note = 0; m_off_p = 1;
    end
  endtask

  always @(posedge clk) begin
    if (!reset) model_clear();
    else        model_step();
    #1;
    if (reset) begin
      chk("env_out",        32'(env_out),        32'(m_env));
      chk("env_valid",      32'(env_valid),      32'(m_valid));
      chk("note_out",       32'(note_out),       32'(m_note));
      chk("note_on_pulse",  32'(note_on_pulse),  32'(m_on_p));
      chk("note_off_pulse", 32'(note_off_pulse), 32'(m_off_p));
`ifdef ENVELOPE_FOLLOWER_PEAK_EN
      chk("peak_out",       32'(peak_out),       32'(m_peak));
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at the next one)
  // ---------------------------------------------------------------------------
  task automatic step(input logic [15:0] s, input logic v);
    sample_in = s;
    sample_valid = v;
    @(negedge clk);
  endtask

  function automatic logic [30:0] pick_rate();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return 31'($urandom_range(1, 32'h00400000));
      2:       return 31'($urandom_range(32'h01000000, 32'h7FFFFFFF));
      default: return '1;
    endcase
  endfunction

  int pulse_at;
  int offs;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_env",   32'(env_out),        32'h0);
    chk("rst_valid", 32'(env_valid),      32'h0);
    chk("rst_note",  32'(note_out),       32'h0);
    chk("rst_on",    32'(note_on_pulse),  32'h0);
    chk("rst_off",   32'(note_off_pulse), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Instantaneous attack, one-cycle latency
    step(16'h4000, 1'b1);
    chk("inst_env",   32'(env_out),   32'h20000000);
    chk("inst_valid", 32'(env_valid), 32'h1);
    step(16'h0000, 1'b0);
    chk("no_upd_env",   32'(env_out),   32'h20000000);
    chk("no_upd_valid", 32'(env_valid), 32'h0);

    // Limited attack ramp clamping at full-scale magnitude
    step(16'h0000, 1'b1);
    chk("ramp_zero", 32'(env_out), 32'h0);
    attack = 31'h01000000;
    for (int k = 1; k <= 66; k++) begin
      step(16'h7FFF, 1'b1);
      if (k == 1 || k == 63 || k == 64 || k == 66)
        chk("ramp_env", 32'(env_out), (k < 64) ? (32'(k) << 24) : 32'h3FFF8000);
    end

    // Gate open with hysteresis
    attack = '0;
    step(16'h0000, 1'b1);
    threshold_on  = 31'h10000000;
    threshold_off = 31'h08000000;
    step(16'h2000, 1'b1);
    chk("open_env",   32'(env_out),       32'h10000000);
    chk("open_pulse", 32'(note_on_pulse), 32'h1);
    chk("open_note",  32'(note_out),      32'h1);
    step(16'h1800, 1'b1);
    chk("hyst_env",  32'(env_out),       32'h0C000000);
    chk("hyst_note", 32'(note_out),      32'h1);
    chk("hyst_on",   32'(note_on_pulse), 32'h0);

    // Hold of 3 ms ticks at MS=10 cycles per tick
    hold_ms = 10'd3;
    step(16'h0800, 1'b1);
    chk("hold_entry_note", 32'(note_out), 32'h1);
    pulse_at = -1;
    for (int k = 1; k <= 40; k++) begin
      step(16'h0000, 1'b0);
      if (k == 29) chk("hold_k29_note", 32'(note_out), 32'h1);
      if (note_off_pulse && pulse_at < 0) pulse_at = k;
    end
    chk("hold_exit_cycle", 32'(pulse_at), 32'd30);
    chk("hold_exit_note",  32'(note_out), 32'h0);

    // Re-open inside the hold window: no pulses, gate stays high
    step(16'h2000, 1'b1);
    chk("reopen_on", 32'(note_on_pulse), 32'h1);
    step(16'h0800, 1'b1);
    repeat (15) step(16'h0000, 1'b0);
    step(16'h2400, 1'b1);
    chk("rehold_note", 32'(note_out),       32'h1);
    chk("rehold_on",   32'(note_on_pulse),  32'h0);
    chk("rehold_off",  32'(note_off_pulse), 32'h0);
    offs = 0;
    for (int k = 0; k < 40; k++) begin
      step(16'h0000, 1'b0);
      if (note_off_pulse) offs++;
    end
    chk("rehold_no_off", 32'(offs),     32'd0);
    chk("rehold_still",  32'(note_out), 32'h1);

    // Reopen coinciding with hold expiry: reopen wins
    hold_ms = 10'd1;
    step(16'h0800, 1'b1);
    repeat (9) step(16'h0000, 1'b0);
    step(16'h2000, 1'b1);
    chk("tie_note", 32'(note_out),       32'h1);
    chk("tie_off",  32'(note_off_pulse), 32'h0);
    chk("tie_on",   32'(note_on_pulse),  32'h0);

    // hold_ms = 0 leaves HOLD the cycle after entry
    hold_ms = 10'd0;
    step(16'h0800, 1'b1);
    chk("h0_entry_note", 32'(note_out), 32'h1);
    step(16'h0000, 1'b0);
    chk("h0_off",  32'(note_off_pulse), 32'h1);
    chk("h0_note", 32'(note_out),       32'h0);

    // Most negative sample, then asynchronous reset mid-note
    step(16'h8000, 1'b1);
    chk("neg_env", 32'(env_out),       32'h40000000);
    chk("neg_on",  32'(note_on_pulse), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("arst_env",  32'(env_out),        32'h0);
    chk("arst_note", 32'(note_out),       32'h0);
    chk("arst_off",  32'(note_off_pulse), 32'h0);
    @(negedge clk);
    chk("arst_hold_off", 32'(note_off_pulse), 32'h0);
    reset = 1'b1;
    attack = 31'h01000000;
    step(16'h7FFF, 1'b1);
    chk("post_rst_env", 32'(env_out), 32'h01000000);
    chk("post_rst_off", 32'(note_off_pulse), 32'h0);

`ifdef ENVELOPE_FOLLOWER_PEAK_EN
    // Peak captured over a note and held after note-off
    attack = '0; rel = '0; hold_ms = '0;
    threshold_on = 31'h10000000; threshold_off = 31'h08000000;
    step(16'h0000, 1'b1);
    step(16'h4000, 1'b1);
    step(16'h6000, 1'b1);
    step(16'h1000, 1'b1);
    step(16'h0800, 1'b1);
    step(16'h0000, 1'b0);
    chk("peak_after_off", 32'(peak_out), 32'h30000000);
    step(16'h0100, 1'b1);
    chk("peak_idle_hold", 32'(peak_out), 32'h30000000);
    step(16'h2000, 1'b1);
    chk("peak_reload", 32'(peak_out), 32'h10000000);
`endif

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        attack = pick_rate();
        rel    = pick_rate();
      end
      if ($urandom_range(0, 31) == 0) begin
        threshold_on  = 31'($urandom_range(0, 32'h40000000));
        threshold_off = 31'($urandom_range(0, 32'h40000000));
        hold_ms       = 10'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else if ($urandom_range(0, 15) == 0) begin
        step(16'h8000, 1'b1);
      end else begin
        step(16'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    step(16'h0000, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
